// File: rtl/stage5_keymix_pipe.sv
// Key-mix pipeline stage: XORs four permuted bytes with rotated copies of the round key
// and buffers results through a two-entry main/skid register pair.
module stage5_keymix_pipe #(
    parameter int unsigned ROUNDS = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Enable,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] a0,
    input  logic [7:0] b0,
    input  logic [7:0] c0,
    input  logic [7:0] d0,
    input  logic [7:0] k,
    output logic [7:0] w0,
    output logic [7:0] x0,
    output logic [7:0] y0,
    output logic [7:0] z0,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] round_cnt,
    output logic       last
);

    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StFull
    } state_e;

    localparam logic [3:0] LastRound = 4'(ROUNDS - 1);

    state_e      state_q;
    logic [31:0] main_q;
    logic [31:0] skid_q;
    logic [3:0]  round_q;
    logic [31:0] mix;
    logic [7:0]  k_rot1;
    logic [7:0]  k_rot2;
    logic [7:0]  k_rot3;
    logic        accept;
    logic        send;

    assign k_rot1 = {k[6:0], k[7]};
    assign k_rot2 = {k[5:0], k[7:6]};
    assign k_rot3 = {k[4:0], k[7:5]};
    assign mix    = {a0 ^ k, b0 ^ k_rot1, c0 ^ k_rot2, d0 ^ k_rot3};

    // Enable gates both handshakes, so with Enable low no register can change.
    assign in_ready  = Enable & (state_q != StFull);
    assign out_valid = Enable & (state_q != StEmpty);
    assign accept    = in_valid & in_ready;
    assign send      = out_valid & out_ready;

    assign {w0, x0, y0, z0} = main_q;
    assign round_cnt        = round_q;
    assign last             = (round_q == LastRound);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StEmpty;
            main_q  <= '0;
            skid_q  <= '0;
            round_q <= '0;
        end else begin
            if (send) begin
                round_q <= (round_q == LastRound) ? 4'd0 : round_q + 4'd1;
            end
            case (state_q)
                StEmpty: begin
                    if (accept) begin
                        main_q  <= mix;
                        state_q <= StOne;
                    end
                end
                StOne: begin
                    if (accept && send) begin
                        main_q <= mix;
                    end else if (accept) begin
                        skid_q  <= mix;
                        state_q <= StFull;
                    end else if (send) begin
                        state_q <= StEmpty;
                    end
                end
                StFull: begin
                    if (send) begin
                        main_q  <= skid_q;
                        state_q <= StOne;
                    end
                end
                default: state_q <= StEmpty;
            endcase
        end
    end

endmodule

// File: tb/tb_stage5_keymix_pipe.sv
// Self-checking bench for stage5_keymix_pipe against a two-deep FIFO reference model.
module tb_stage5_keymix_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic       Enable;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a0, b0, c0, d0, k;
    logic [7:0] w0, x0, y0, z0;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] round_cnt;
    logic       last;

    int errors = 0;
    int checks = 0;

    // Reference model: queue of pending groups (capacity 2), displayed word, send count.
    logic [31:0] mq[$];
    logic [31:0] shown;
    int unsigned rc;

    stage5_keymix_pipe #(.ROUNDS(16)) dut (
        .clk(clk),
        .reset(reset),
        .Enable(Enable),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a0(a0),
        .b0(b0),
        .c0(c0),
        .d0(d0),
        .k(k),
        .w0(w0),
        .x0(x0),
        .y0(y0),
        .z0(z0),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .round_cnt(round_cnt),
        .last(last)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        if (n == 0) return v;
        return 8'(v << n) | 8'(v >> (8 - n));
    endfunction

    function automatic logic [31:0] mixf(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] c, input logic [7:0] d,
                                         input logic [7:0] kk);
        return {a ^ kk, b ^ rotl(kk, 1), c ^ rotl(kk, 2), d ^ rotl(kk, 3)};
    endfunction

    function automatic logic [31:0] cur_mix();
        return mixf(a0, b0, c0, d0, k);
    endfunction

    function automatic logic exp_in_ready();
        return Enable && (mq.size() < 2);
    endfunction

    function automatic logic exp_out_valid();
        return Enable && (mq.size() > 0);
    endfunction

    task automatic model_edge();
        logic acc, snd;
        if (!reset) begin
            mq.delete();
            shown = '0;
            rc = 0;
        end else if (Enable) begin
            acc = in_valid && (mq.size() < 2);
            snd = out_ready && (mq.size() > 0);
            if (snd) begin
                void'(mq.pop_front());
                rc = (rc + 1) % 16;
            end
            if (acc) mq.push_back(cur_mix());
            if (mq.size() > 0) shown = mq[0];
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        a0 = 8'($urandom);
        b0 = 8'($urandom);
        c0 = 8'($urandom);
        d0 = 8'($urandom);
        k  = 8'($urandom);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        Enable = 1'b1;
        do_reset();
        checks++;
        if ({w0, x0, y0, z0} !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got %h want 00000000", {w0, x0, y0, z0});
        end
        checks++;
        if ({out_valid, round_cnt, last, in_ready} !== 7'b0_0000_0_1) begin
            errors++;
            $display("FAIL reset_ctrl: got ov=%b rc=%0d last=%b ir=%b want 0 0 0 1",
                     out_valid, round_cnt, last, in_ready);
        end
        Enable = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ir_disabled: got %b want 0", in_ready);
        end
        Enable = 1'b1;
    endtask

    task automatic test_basic();
        do_reset();
        a0 = 8'h11; b0 = 8'h22; c0 = 8'h33; d0 = 8'h44; k = 8'h81;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        rand_data();
        checks++;
        if ({w0, x0, y0, z0} !== 32'h90213548 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_mix: got %h ov=%b want 90213548 ov=1",
                     {w0, x0, y0, z0}, out_valid);
        end
        tick();
        checks++;
        if (round_cnt !== 4'd1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_count: got rc=%0d ov=%b want rc=1 ov=0", round_cnt, out_valid);
        end
    endtask

    task automatic fill_two(output logic [31:0] g0, output logic [31:0] g1);
        out_ready = 1'b0;
        in_valid = 1'b1;
        rand_data();
        g0 = cur_mix();
        tick();
        rand_data();
        g1 = cur_mix();
        tick();
    endtask

    task automatic test_backpressure();
        logic [31:0] g0, g1;
        do_reset();
        fill_two(g0, g1);
        rand_data();
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || {w0, x0, y0, z0} !== g0) begin
            errors++;
            $display("FAIL bp_full: got ir=%b ov=%b data=%h want ir=0 ov=1 data=%h",
                     in_ready, out_valid, {w0, x0, y0, z0}, g0);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if ({w0, x0, y0, z0} !== g1 || in_ready !== 1'b1 || round_cnt !== 4'd1) begin
            errors++;
            $display("FAIL bp_second: got data=%h ir=%b rc=%0d want data=%h ir=1 rc=1",
                     {w0, x0, y0, z0}, in_ready, round_cnt, g1);
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || round_cnt !== 4'd2 || {w0, x0, y0, z0} !== g1) begin
            errors++;
            $display("FAIL bp_drain: got ov=%b rc=%0d data=%h want ov=0 rc=2 data=%h",
                     out_valid, round_cnt, {w0, x0, y0, z0}, g1);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] g;
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rand_data();
            g = cur_mix();
            tick();
            checks++;
            if ({w0, x0, y0, z0} !== g || out_valid !== 1'b1 || round_cnt !== 4'(i) ||
                last !== (i == 15)) begin
                errors++;
                $display("FAIL b2b_%0d: got data=%h ov=%b rc=%0d last=%b want %h 1 %0d %b",
                         i, {w0, x0, y0, z0}, out_valid, round_cnt, last, g, i, i == 15);
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (round_cnt !== 4'd0 || last !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_wrap: got rc=%0d last=%b ov=%b want 0 0 0",
                     round_cnt, last, out_valid);
        end
    endtask

    task automatic test_enable();
        logic [31:0] g0, g1;
        do_reset();
        fill_two(g0, g1);
        Enable = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_data();
            #1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL en_hs_%0d: got ir=%b ov=%b want 0 0", i, in_ready, out_valid);
            end
            tick();
            checks++;
            if ({w0, x0, y0, z0} !== g0 || round_cnt !== 4'd0) begin
                errors++;
                $display("FAIL en_hold_%0d: got data=%h rc=%0d want %h 0",
                         i, {w0, x0, y0, z0}, round_cnt, g0);
            end
        end
        Enable = 1'b1;
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL en_resume: got ov=%b ir=%b want 1 0", out_valid, in_ready);
        end
        tick();
        checks++;
        if ({w0, x0, y0, z0} !== g1 || round_cnt !== 4'd1) begin
            errors++;
            $display("FAIL en_drain: got data=%h rc=%0d want %h 1",
                     {w0, x0, y0, z0}, round_cnt, g1);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_valid = 1'b1;
        out_ready = 1'b1;
        rand_data();
        tick();
        rand_data();
        tick();
        out_ready = 1'b0;
        rand_data();
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || {w0, x0, y0, z0} !== 32'h0 || round_cnt !== 4'd0) begin
            errors++;
            $display("FAIL rmid_clear: got ov=%b data=%h rc=%0d want 0 00000000 0",
                     out_valid, {w0, x0, y0, z0}, round_cnt);
        end
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || round_cnt !== 4'd0) begin
                errors++;
                $display("FAIL rmid_lost_%0d: got ov=%b rc=%0d want 0 0", i, out_valid, round_cnt);
            end
        end
    endtask

    task automatic test_random();
        logic exp_ir, exp_ov;
        do_reset();
        for (int i = 0; i < 1000; i++) begin
            Enable = ($urandom_range(0, 9) != 0);
            in_valid = 1'($urandom);
            out_ready = 1'($urandom);
            rand_data();
            #1;
            exp_ir = exp_in_ready();
            exp_ov = exp_out_valid();
            checks++;
            if (in_ready !== exp_ir || out_valid !== exp_ov) begin
                errors++;
                $display("FAIL rnd_hs_%0d: got ir=%b ov=%b want %b %b",
                         i, in_ready, out_valid, exp_ir, exp_ov);
            end
            tick();
            checks++;
            if ({w0, x0, y0, z0} !== shown || round_cnt !== 4'(rc) ||
                last !== (rc == 15)) begin
                errors++;
                $display("FAIL rnd_data_%0d: got data=%h rc=%0d last=%b want %h %0d %b",
                         i, {w0, x0, y0, z0}, round_cnt, last, shown, rc, rc == 15);
            end
        end
        Enable = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        Enable = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a0 = '0; b0 = '0; c0 = '0; d0 = '0; k = '0;
        shown = '0;
        rc = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_enable();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
